// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types for the instruction/data memory port arbiter
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [3:0] WE_NONE_L = 4'b1111;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin picker, purely combinational
import riscv_mem_pkg::*;

module rr_arb2 (
    input  logic   req_if,
    input  logic   req_d,
    input  owner_t last_owner,
    output logic   valid,
    output owner_t pick
);

    always_comb begin
        valid = req_if | req_d;
        pick  = OWN_IF;
        if (req_if && req_d) begin
            // On a tie the requester that was not served last goes next
            pick = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
        end else if (req_d) begin
            pick = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store, one access in flight
import riscv_mem_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_WE_L,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_WE_L,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    arb_state_t       state;
    owner_t           owner;
    owner_t           last_owner;
    owner_t           pick;
    logic             pick_valid;
    logic [CNT_W-1:0] wd_cnt;
    logic             timeout;
    logic             is_store;
    logic [DATA_W-1:0] resp_data;

    rr_arb2 u_rr_arb2 (
        .req_if     (if_req),
        .req_d      (d_req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .pick       (pick)
    );

    assign timeout   = (wd_cnt == CNT_MAX);
    assign is_store  = (mem_WE_L != WE_NONE_L);
    assign resp_data = is_store ? '0 : mem_rdata;

    assign mem_req = (state == REQ);
    assign busy    = (state != IDLE);
    assign if_gnt  = (state == REQ) && mem_ready && (owner == OWN_IF);
    assign d_gnt   = (state == REQ) && mem_ready && (owner == OWN_D);

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            wd_cnt     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_WE_L   <= WE_NONE_L;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            err       <= 1'b0;
            if (state != IDLE && wd_cnt != CNT_MAX) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= REQ;
                        owner      <= pick;
                        last_owner <= pick;
                        wd_cnt     <= '0;
                        if (pick == OWN_D) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_WE_L  <= d_WE_L;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_WE_L  <= WE_NONE_L;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state <= WAIT;
                    end else if (timeout) begin
                        // Abandon the access; the owner sees a zero response flagged by err
                        state <= IDLE;
                        err   <= 1'b1;
                        if (owner == OWN_D) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid || timeout) begin
                        state <= IDLE;
                        err   <= ~mem_rvalid;
                        if (owner == OWN_D) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_rvalid ? resp_data : '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rvalid ? resp_data : '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_L;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_WE_L;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_WE_L;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clock      (clock),
        .reset_L    (reset_L),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_WE_L     (d_WE_L),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_WE_L   (mem_WE_L),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .err        (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic is_d, input logic [31:0] data, input logic e_err);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.err  = e_err;
        exp_q.push_back(e);
    endtask

    // Responses are compared in the middle of each cycle against the queue of expectations
    always @(negedge clock) begin
        if (if_rvalid || d_rvalid || err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_response", 64'({if_rvalid, d_rvalid, err}), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_d_rvalid", 64'(d_rvalid), 64'(mon_e.is_d));
                chk("resp_if_rvalid", 64'(if_rvalid), 64'(!mon_e.is_d));
                chk("resp_err", 64'(err), 64'(mon_e.err));
                chk("resp_rdata", 64'(mon_e.is_d ? d_rdata : if_rdata), 64'(mon_e.data));
            end
        end
    end

    task automatic serve(input logic is_d, input logic [31:0] addr, input logic [3:0] we,
                         input logic [31:0] wdata, input int rdy_dly, input int rv_dly,
                         input logic [31:0] rdata);
        int n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", 64'(mem_req), 64'(1));
        for (int i = 0; i < rdy_dly; i++) begin
            if (is_d) begin
                d_addr  = $urandom;
                d_wdata = $urandom;
            end else begin
                if_addr = $urandom;
            end
            #1;
            chk("hold_addr", 64'(mem_addr), 64'(addr));
            chk("hold_we", 64'(mem_WE_L), 64'(we));
            chk("hold_wdata", 64'(mem_wdata), 64'(wdata));
            chk("no_early_gnt", 64'({if_gnt, d_gnt}), 64'(0));
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("if_gnt", 64'(if_gnt), 64'(!is_d));
        chk("d_gnt", 64'(d_gnt), 64'(is_d));
        chk("gnt_addr", 64'(mem_addr), 64'(addr));
        chk("gnt_we", 64'(mem_WE_L), 64'(we));
        chk("gnt_wdata", 64'(mem_wdata), 64'(wdata));
        step();
        mem_ready = 1'b0;
        if (is_d) d_req = 1'b0;
        else      if_req = 1'b0;
        repeat (rv_dly) step();
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        push(is_d, (we == 4'b1111) ? rdata : 32'h0, 1'b0);
        step();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_L = 0; if_req = 0; if_addr = 0; d_req = 0; d_addr = 0; d_wdata = 0;
        d_WE_L = 4'hF; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) step();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_we", 64'(mem_WE_L), 64'(4'hF));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_pulses", 64'({if_rvalid, d_rvalid, err, if_gnt, d_gnt}), 64'(0));
        chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'(0));

        // Single fetch with cycle-exact timing
        reset_L = 1; if_req = 1; if_addr = 32'h100;
        #1;
        chk("c0_mem_req", 64'(mem_req), 64'(0));
        step();
        mem_ready = 1;
        #1;
        chk("c1_mem_req", 64'(mem_req), 64'(1));
        chk("c1_if_gnt", 64'(if_gnt), 64'(1));
        chk("c1_mem_addr", 64'(mem_addr), 64'(32'h100));
        chk("c1_mem_we", 64'(mem_WE_L), 64'(4'hF));
        push(1'b0, 32'h13, 1'b0);
        step();
        if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h13;
        chk("c2_mem_req", 64'(mem_req), 64'(0));
        chk("c2_busy", 64'(busy), 64'(1));
        step();
        mem_rvalid = 0;
        chk("c3_if_rvalid", 64'(if_rvalid), 64'(1));
        chk("c3_if_rdata", 64'(if_rdata), 64'(32'h13));
        chk("c3_busy", 64'(busy), 64'(0));

        // Simultaneous requests alternate, data first after reset
        if_req = 1; if_addr = 32'h400; d_req = 1; d_addr = 32'h2000; d_WE_L = 4'hF; d_wdata = 32'h0;
        serve(1'b1, 32'h2000, 4'hF, 32'h0, 0, 0, 32'hAAAA0001);
        serve(1'b0, 32'h400, 4'hF, 32'h0, 0, 0, 32'h00100093);
        if_req = 1; if_addr = 32'h404; d_req = 1; d_addr = 32'h2004; d_wdata = 32'h0;
        serve(1'b1, 32'h2004, 4'hF, 32'h0, 0, 0, 32'hBBBB0002);
        serve(1'b0, 32'h404, 4'hF, 32'h0, 0, 0, 32'h00200113);

        // Memory never answers: timeout 16 cycles after REQ entry
        d_req = 1; d_addr = 32'h4000; d_WE_L = 4'hF; d_wdata = 32'h0;
        step();
        chk("to_c1_mem_req", 64'(mem_req), 64'(1));
        chk("to_c1_addr", 64'(mem_addr), 64'(32'h4000));
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_busy", 64'(busy), 64'(1));
            chk("to_no_gnt_err", 64'({d_gnt, err, d_rvalid}), 64'(0));
        end
        push(1'b1, 32'h0, 1'b1);
        step();
        d_req = 0;
        chk("to_err", 64'(err), 64'(1));
        chk("to_d_rvalid", 64'(d_rvalid), 64'(1));
        chk("to_d_rdata", 64'(d_rdata), 64'(0));
        chk("to_busy_drop", 64'(busy), 64'(0));

        // Progress on the exact timeout cycle wins over the watchdog
        d_req = 1; d_addr = 32'h6000; d_WE_L = 4'hF; d_wdata = 32'h0;
        serve(1'b1, 32'h6000, 4'hF, 32'h0, 0, 14, 32'hCAFEF00D);
        if_req = 1; if_addr = 32'h700;
        serve(1'b0, 32'h700, 4'hF, 32'h0, 15, 0, 32'h00000093);

        // Store with delayed ready: latched values hold, store response is zero
        d_req = 1; d_addr = 32'h3000; d_WE_L = 4'b1100; d_wdata = 32'hDEADBEEF;
        serve(1'b1, 32'h3000, 4'b1100, 32'hDEADBEEF, 4, 0, 32'h55555555);
        chk("st_d_rdata", 64'(d_rdata), 64'(0));

        // Reset during WAIT, then a late mem_rvalid must be ignored
        d_req = 1; d_addr = 32'h5000; d_WE_L = 4'hF; d_wdata = 32'h0;
        step();
        mem_ready = 1;
        step();
        mem_ready = 0; d_req = 0; reset_L = 0;
        chk("mr_in_wait", 64'(busy), 64'(1));
        step();
        reset_L = 1; mem_rvalid = 1; mem_rdata = 32'h12345678;
        chk("mr_busy", 64'(busy), 64'(0));
        chk("mr_mem_we", 64'(mem_WE_L), 64'(4'hF));
        chk("mr_mem_req", 64'(mem_req), 64'(0));
        step();
        mem_rvalid = 0;
        chk("mr_no_rvalid", 64'({if_rvalid, d_rvalid, err}), 64'(0));
        chk("mr_still_idle", 64'(busy), 64'(0));

        // last_owner was data before reset, yet data must win the first tie after it
        if_req = 1; if_addr = 32'h800; d_req = 1; d_addr = 32'h2800;
        serve(1'b1, 32'h2800, 4'hF, 32'h0, 0, 0, 32'h0000BEEF);
        serve(1'b0, 32'h800, 4'hF, 32'h0, 0, 0, 32'h00000013);

        repeat (2) step();
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
